wb_arb2: RTL and testbench

- Two-master to one-slave Wishbone classic arbiter placed directly upstream of the on-chip RAM wrapper.
- Master 0 is the core instruction port; master 1 is the core data port or external/debug port.
- Arbitration is round-robin with registered grant.
- Absorbs the RAM slave's trailing duplicate ack: the slave acks every cycle it sees cyc&stb, so one master transfer can produce two acks. Enforces exactly one ack per master transfer and adds a timeout watchdog.

---
 rtl/wb_arb2.sv | 80 ++++++++
 tb/tb_wb_arb2.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2.sv
// wb_arb2: two-master round-robin Wishbone classic arbiter in front of a RAM slave,
// dropping the slave's trailing duplicate ack and erroring out stalled transfers.
module wb_arb2 #(
  parameter int AW = 10,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [31:0]   m0_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [31:0]   m1_dat_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  input  logic          s_ack_i,
  input  logic [31:0]   s_dat_i
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_t;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, arb;
  logic prio_q;
  logic [TW-1:0] tmo_q;
  logic req0, req1, gnt0, gnt1, req_g, tmo_hit;
  always_comb begin
    req0 = m0_cyc_i & m0_stb_i;
    req1 = m1_cyc_i & m1_stb_i;
    gnt0 = state == GNT0;
    gnt1 = state == GNT1;
    req_g = gnt1 ? req1 : req0;
    tmo_hit = TIMEOUT > 0 && req_g && !s_ack_i && tmo_q == TW'(TIMEOUT - 1);
    arb = (req0 & req1) ? (prio_q ? GNT1 : GNT0) : req0 ? GNT0 : req1 ? GNT1 : IDLE;
  end
  // Ack is qualified by the live request so an aborted transfer never sees a late ack.
  assign m0_ack_o = gnt0 & s_ack_i & req0;
  assign m1_ack_o = gnt1 & s_ack_i & req1;
  assign m0_err_o = gnt0 & tmo_hit;
  assign m1_err_o = gnt1 & tmo_hit;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign s_cyc_o = gnt0 ? m0_cyc_i : gnt1 ? m1_cyc_i : 1'b0;
  assign s_stb_o = gnt0 ? m0_stb_i : gnt1 ? m1_stb_i : 1'b0;
  assign s_we_o  = gnt0 ? m0_we_i  : gnt1 ? m1_we_i  : 1'b0;
  assign s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
  assign s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
  // Every exit from a grant goes through DRAIN, which swallows the slave's second ack.
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      prio_q <= 1'b0;
      tmo_q <= '0;
    end else if (gnt0 || gnt1) begin
      if (!req_g || s_ack_i || tmo_hit) begin
        state <= DRAIN;
        prio_q <= gnt0;
        tmo_q <= '0;
      end else tmo_q <= tmo_q + TW'(1);
    end else begin
      state <= arb;
      tmo_q <= '0;
    end
endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: scoreboard bench for wb_arb2 with a registered-ack RAM slave model
// that acks every cycle it sees cyc&stb.
module tb_wb_arb2;
  localparam int AW = 10;
  localparam int TO = 16;
  typedef struct {bit is_err; bit rd; logic [31:0] dat; int issue; int lat;} exp_t;
  typedef struct {bit we; bit ab; logic [AW-1:0] adr; logic [31:0] dat; logic [3:0] sel; int dly; int lat; bit ex_err;} op_t;
  logic clk = 0, rst = 1;
  logic cyc [2], stb [2], we [2];
  logic [3:0] sel [2];
  logic [AW-1:0] adr [2];
  logic [31:0] wdat [2], rdat [2];
  logic ack [2], err [2];
  logic s_cyc, s_stb, s_we, s_ack;
  logic [3:0] s_sel;
  logic [AW-1:0] s_adr;
  logic [31:0] s_wdat, s_rdat;
  bit ack_en = 1;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  exp_t q [2][$];
  op_t ops [2][$];
  op_t cur [2];
  bit act [2], ab [2], pend [2], got [2];
  int cyc_n = 0, total = 0, bad = 0, stuck = 0, chk_mode = 0;
  bit fin = 0;
  exp_t me;
  bit ok, hit;
  wb_arb2 #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]), .m0_dat_o(rdat[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]), .m1_dat_o(rdat[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  function automatic logic [31:0] init_val(int i);
    return i == 5 ? 32'hDEADBEEF : (32'h5A00_0000 | (i * 32'h0001_0003)) ^ 32'h0000_F0F0;
  endfunction
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b+:8] = n[8*b+:8];
    return o;
  endfunction
  // RAM slave: registered ack and read data, acking every cycle it is strobed.
  always @(posedge clk)
    if (rst) begin
      s_ack <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else begin
      s_ack <= ack_en && s_cyc && s_stb;
      s_rdat <= mem[s_adr];
      if (s_cyc && s_stb && s_we)
        for (int b = 0; b < 4; b++) if (s_sel[b]) mem[s_adr][8*b+:8] <= s_wdat[8*b+:8];
    end
  // Monitor: pops the scoreboard on every ack/err and checks slave-port routing.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (ack[k] || err[k]) begin
        total++;
        if (q[k].size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp m%0d ack=%b err=%b cycle=%0d", k, ack[k], err[k], cyc_n);
        end else begin
          me = q[k].pop_front();
          ok = err[k] == me.is_err && ack[k] != me.is_err && rdat[0] == rdat[1]
            && (!me.rd || me.is_err || rdat[k] == me.dat)
            && (me.lat > 0 ? cyc_n - me.issue == me.lat : (cyc_n - me.issue >= 2 && cyc_n - me.issue <= 5));
          if (!ok) begin
            bad++;
            $display("FAIL resp m%0d: got ack=%b err=%b dat=%h lat=%0d, want err=%b dat=%h lat=%0d",
              k, ack[k], err[k], rdat[k], cyc_n - me.issue, me.is_err, me.dat, me.lat);
          end
        end
      end
    if (s_cyc && s_stb) begin
      total++;
      hit = 0;
      for (int k = 0; k < 2; k++)
        if (cyc[k] && stb[k] && s_we == we[k] && s_sel == sel[k] && s_adr == adr[k] && s_wdat == wdat[k]) hit = 1;
      if (!hit) begin
        bad++;
        $display("FAIL slave_port we=%b sel=%b adr=%h dat=%h matches no requesting master", s_we, s_sel, s_adr, s_wdat);
      end
    end
    if (chk_mode == 1) begin
      total++;
      if (s_cyc !== 0 || ack[0] !== 0 || ack[1] !== 0 || err[0] !== 0 || err[1] !== 0) begin
        bad++;
        $display("FAIL idle: s_cyc=%b ack=%b%b err=%b%b, want all 0", s_cyc, ack[0], ack[1], err[0], err[1]);
      end
    end
    if (chk_mode == 2) begin
      total++;
      if (s_cyc !== 1) begin
        bad++;
        $display("FAIL granted: s_cyc=%b, want 1", s_cyc);
      end
    end
    if (fin) begin
      total++;
      if (q[0].size() != 0 || q[1].size() != 0 || stuck != 0) begin
        bad++;
        $display("FAIL drained: pending=%0d/%0d stuck_phases=%0d, want 0/0/0", q[0].size(), q[1].size(), stuck);
      end
    end
  end
  task automatic add(int k, bit w, logic [AW-1:0] a, logic [31:0] d, logic [3:0] s, int dly, int lat, bit abt = 0, bit e = 0);
    op_t o;
    o = '{we: w, ab: abt, adr: a, dat: d, sel: s, dly: dly, lat: lat, ex_err: e};
    ops[k].push_back(o);
  endtask
  task automatic step(int k);
    if (act[k] && (got[k] || ab[k])) begin
      act[k] = 0; got[k] = 0; cyc[k] = 0; stb[k] = 0;
    end
    if (!act[k] && !pend[k] && ops[k].size() != 0) begin
      cur[k] = ops[k].pop_front();
      pend[k] = 1;
    end
    if (pend[k]) begin
      if (cur[k].dly > 0) cur[k].dly--;
      else begin
        pend[k] = 0; act[k] = 1; ab[k] = cur[k].ab;
        cyc[k] = 1; stb[k] = 1; we[k] = cur[k].we;
        adr[k] = cur[k].adr; wdat[k] = cur[k].dat; sel[k] = cur[k].sel;
        if (!cur[k].ab) begin
          q[k].push_back('{is_err: cur[k].ex_err, rd: !cur[k].we, dat: ref_mem[cur[k].adr], issue: cyc_n, lat: cur[k].lat});
          if (cur[k].we) ref_mem[cur[k].adr] = merge(ref_mem[cur[k].adr], cur[k].dat, cur[k].sel);
        end
      end
    end
  endtask
  task automatic run_phase(int budget);
    int n = 0;
    while ((ops[0].size() != 0 || ops[1].size() != 0 || act[0] || act[1] || pend[0] || pend[1]) && n < budget) begin
      @(posedge clk); #1;
      n++;
      step(0);
      step(1);
      @(negedge clk);
      for (int k = 0; k < 2; k++) got[k] = ack[k] | err[k];
    end
    if (n >= budget) stuck++;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0; stb[k] = 0; act[k] = 0; pend[k] = 0; got[k] = 0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; sel[k] = 0; adr[k] = 0; wdat[k] = 0;
    end
    do_reset();
    chk_mode = 1;
    repeat (10) @(posedge clk);
    #1 chk_mode = 0;
    // Single read plus a boundary-address write/read on master 0.
    add(0, 0, 10'h005, 32'h0, 4'hF, 0, 2);
    add(0, 1, 10'h000, 32'h1234_5678, 4'hF, 2, 2);
    add(0, 0, 10'h000, 32'h0, 4'hF, 2, 2);
    run_phase(100);
    // Simultaneous requests after reset, then continuous alternation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add(0, 1, 10'(2 * i + 8), 32'hA000_0000 + i, 4'hF, 0, i == 0 ? 2 : 5);
      add(1, 1, 10'(2 * i + 9), 32'hB000_0000 + i, 4'hF, 0, 5);
    end
    run_phase(200);
    add(1, 1, 10'h3FF, 32'h0000_AB00, 4'b0010, 0, 2);
    add(1, 0, 10'h3FF, 32'h0, 4'hF, 0, 2);
    run_phase(100);
    // m0 aborts right after grant; m1 requested meanwhile is granted out of DRAIN.
    add(0, 0, 10'h010, 32'h0, 4'hF, 0, 0, 1);
    add(1, 0, 10'h011, 32'h0, 4'hF, 1, 3);
    run_phase(100);
    ack_en = 0;
    add(0, 0, 10'h020, 32'h0, 4'hF, 0, 16, 0, 1);
    run_phase(100);
    ack_en = 1;
    // Reset lands while m1 holds the grant; prio must return to master 0.
    do_reset();
    add(0, 1, 10'h040, 32'hC0C0_0001, 4'hF, 0, 2);
    add(1, 1, 10'h041, 32'hC1C1_0001, 4'hF, 0, 5);
    run_phase(100);
    ack_en = 0;
    @(posedge clk); #1;
    cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 10'h001; sel[1] = 4'hF;
    @(posedge clk); #1;
    rst = 1; chk_mode = 2;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    @(posedge clk); #1;
    rst = 0; chk_mode = 1;
    @(posedge clk); #1;
    chk_mode = 0; cyc[1] = 0; stb[1] = 0; ack_en = 1;
    repeat (3) @(posedge clk);
    // Random traffic on disjoint address halves so each master's data is predictable.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 60; i++) begin
        logic [AW-1:0] a;
        a = {9'($urandom), 1'(k)};
        if ($urandom_range(0, 9) == 0) a = k == 1 ? 10'h3FF : 10'h000;
        add(k, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), 0);
      end
    run_phase(3000);
    repeat (3) @(posedge clk);
    #1 fin = 1;
    @(negedge clk);
    @(posedge clk); #1 fin = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
